// File: rtl/accel_sequencer.sv
// accel_sequencer: drives an SPI master through power-up, WHO_AM_I check,
// two config writes, then periodic X/Y/Z reads presented as 16-bit samples.
module accel_sequencer #(
    parameter logic [31:0] STARTUP_CYCLES = 32'd120000,
    parameter logic [31:0] PERIOD_CYCLES  = 32'd1200000,
    parameter logic [7:0]  WHOAMI_VALUE   = 8'h33,
    parameter logic [7:0]  CTRL1_VALUE    = 8'h77,
    parameter logic [7:0]  CTRL4_VALUE    = 8'h88
) (
    input  logic        clk_in,
    input  logic        rst,
    output logic [31:0] spi_mosi_data,
    output logic [5:0]  spi_nbits,
    output logic        spi_request,
    input  logic [31:0] spi_miso_data,
    input  logic        spi_ready,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        data_valid,
    output logic        id_ok,
    output logic        id_err
);
    typedef enum logic [2:0] {
        ST_STARTUP, ST_ISSUE, ST_SETTLE, ST_WAIT, ST_STORE, ST_PERIOD, ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] mosi_q, mosi_d;
    logic [5:0]  nbits_q, nbits_d;
    logic [15:0] sx_q, sx_d, sy_q, sy_d;
    logic [15:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic        valid_q, valid_d, ok_q, ok_d, err_q, err_d;
    logic [15:0] sample;
    logic        startup_done, period_done, unused_miso;

    // Device returns the low byte first, so it lands in [15:8].
    assign sample       = {spi_miso_data[7:0], spi_miso_data[15:8]};
    assign unused_miso  = ^spi_miso_data[31:16];
    // Compare in 33 bits so that limits of 0 and 1 both mean one cycle.
    assign startup_done = ({1'b0, timer_q} + 33'd1) >= {1'b0, STARTUP_CYCLES};
    assign period_done  = ({1'b0, timer_q} + 33'd1) >= {1'b0, PERIOD_CYCLES};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        timer_d = timer_q;
        mosi_d  = mosi_q;
        nbits_d = nbits_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        az_d    = az_q;
        valid_d = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;
        case (state_q)
            ST_STARTUP: begin
                timer_d = startup_done ? 32'd0 : timer_q + 32'd1;
                state_d = startup_done ? ST_ISSUE : ST_STARTUP;
            end
            ST_PERIOD: begin
                timer_d = period_done ? 32'd0 : timer_q + 32'd1;
                state_d = period_done ? ST_ISSUE : ST_PERIOD;
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT:   state_d = spi_ready ? ST_STORE : ST_WAIT;
            ST_STORE: begin
                state_d = ST_ISSUE;
                step_d  = step_q + 3'd1;
                case (step_q)
                    3'd0: begin
                        ok_d    = spi_miso_data[7:0] == WHOAMI_VALUE;
                        err_d   = spi_miso_data[7:0] != WHOAMI_VALUE;
                        state_d = ok_d ? ST_ISSUE : ST_HALT;
                        step_d  = ok_d ? 3'd1 : step_q;
                    end
                    3'd3: sx_d = sample;
                    3'd4: sy_d = sample;
                    3'd5: begin
                        ax_d    = sx_q;
                        ay_d    = sy_q;
                        az_d    = sample;
                        valid_d = 1'b1;
                        step_d  = 3'd3;
                        state_d = ST_PERIOD;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_HALT;
        endcase
        // Command is registered on entry to ISSUE so it is stable alongside the request.
        if (state_d == ST_ISSUE) begin
            mosi_d  = step_d == 3'd0 ? 32'h0000_8F00 :
                      step_d == 3'd1 ? {16'h0, 8'h20, CTRL1_VALUE} :
                      step_d == 3'd2 ? {16'h0, 8'h23, CTRL4_VALUE} :
                      step_d == 3'd3 ? 32'h00E8_0000 :
                      step_d == 3'd4 ? 32'h00EA_0000 : 32'h00EC_0000;
            nbits_d = step_d < 3'd3 ? 6'd15 : 6'd23;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_STARTUP;
            step_q  <= 3'd0;
            timer_q <= 32'd0;
            mosi_q  <= 32'd0;
            nbits_q <= 6'd0;
            sx_q    <= 16'd0;
            sy_q    <= 16'd0;
            ax_q    <= 16'd0;
            ay_q    <= 16'd0;
            az_q    <= 16'd0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            mosi_q  <= mosi_d;
            nbits_q <= nbits_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            az_q    <= az_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign spi_mosi_data = mosi_q;
    assign spi_nbits     = nbits_q;
    assign spi_request   = state_q == ST_ISSUE;
    assign accel_x       = ax_q;
    assign accel_y       = ay_q;
    assign accel_z       = az_q;
    assign data_valid    = valid_q;
    assign id_ok         = ok_q;
    assign id_err        = err_q;
endmodule

// File: tb/tb_accel_sequencer.sv
// tb_accel_sequencer: SPI slave model plus request/sample scoreboards for accel_sequencer.
module tb_accel_sequencer;
    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] spi_mosi_data, spi_miso_data;
    logic [5:0]  spi_nbits;
    logic        spi_request, spi_ready, data_valid, id_ok, id_err;
    logic [15:0] accel_x, accel_y, accel_z;

    int checks = 0, errors = 0, nreq = 0, nvalid = 0;
    logic [7:0]  whoami;
    logic [15:0] xv[4], yv[4], zv[4];
    logic [37:0] exp_req[$];
    logic [47:0] exp_out[$];

    accel_sequencer #(.STARTUP_CYCLES(32'd4), .PERIOD_CYCLES(32'd20)) dut (
        .clk_in(clk_in), .rst(rst), .spi_mosi_data(spi_mosi_data), .spi_nbits(spi_nbits),
        .spi_request(spi_request), .spi_miso_data(spi_miso_data), .spi_ready(spi_ready),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .data_valid(data_valid),
        .id_ok(id_ok), .id_err(id_err));

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [31:0] m, input logic [5:0] n);
        exp_req.push_back({m, n});
    endtask

    task automatic push_init();
        push_req(32'h0000_8F00, 6'd15);
        push_req(32'h0000_2077, 6'd15);
        push_req(32'h0000_2388, 6'd15);
    endtask

    task automatic push_set(input int i, input bit with_out);
        push_req(32'h00E8_0000, 6'd23);
        push_req(32'h00EA_0000, 6'd23);
        push_req(32'h00EC_0000, 6'd23);
        if (with_out) exp_out.push_back({xv[i], yv[i], zv[i]});
    endtask

    // Slave: ready low for a random number of cycles per transfer, then high with the reply.
    int cnt, sidx, scyc, last_x, bsum, b;
    logic [7:0] cmd;
    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            spi_ready     <= 1'b1;
            spi_miso_data <= 32'd0;
            cnt = 0; sidx = 0; last_x = -1; bsum = 0;
        end else begin
            scyc++;
            if (spi_request) begin
                b = $urandom_range(1, 6);
                cnt = b;
                spi_ready <= 1'b0;
                cmd = (spi_nbits == 6'd15) ? spi_mosi_data[15:8] : spi_mosi_data[23:16];
                case (cmd)
                    8'h8F: spi_miso_data <= {24'h0, whoami};
                    8'hE8: begin
                        // X-to-X spacing: period, ready-low time of the previous set, 3 overhead cycles per axis.
                        if (last_x >= 0) chk("x_period_gap", 64'(scyc - last_x), 64'(20 + bsum + 9));
                        last_x = scyc;
                        bsum = b;
                        spi_miso_data <= {16'h0, xv[sidx][7:0], xv[sidx][15:8]};
                    end
                    8'hEA: begin
                        bsum += b;
                        spi_miso_data <= {16'h0, yv[sidx][7:0], yv[sidx][15:8]};
                    end
                    8'hEC: begin
                        bsum += b;
                        spi_miso_data <= {16'h0, zv[sidx][7:0], zv[sidx][15:8]};
                        sidx++;
                    end
                    default: spi_miso_data <= $urandom;
                endcase
            end else if (!spi_ready) begin
                if (cnt <= 1) spi_ready <= 1'b1;
                else cnt--;
            end
        end
    end

    logic [47:0] prev;
    logic [37:0] er;
    logic [47:0] eo;
    always @(negedge clk_in) begin
        if (rst) prev = 48'd0;
        else begin
            if (spi_request) begin
                nreq++;
                if (exp_req.size() == 0) chk("unexpected_request", {26'd0, spi_mosi_data, spi_nbits}, 64'd0);
                else begin
                    er = exp_req.pop_front();
                    chk("request_cmd", {26'd0, spi_mosi_data, spi_nbits}, {26'd0, er});
                end
            end
            if (data_valid) begin
                nvalid++;
                if (exp_out.size() == 0) chk("unexpected_valid", {16'd0, accel_x, accel_y, accel_z}, 64'd0);
                else begin
                    eo = exp_out.pop_front();
                    chk("accel_xyz", {16'd0, accel_x, accel_y, accel_z}, {16'd0, eo});
                end
            end else if ({accel_x, accel_y, accel_z} != prev)
                chk("accel_change_without_valid", {16'd0, accel_x, accel_y, accel_z}, {16'd0, prev});
            prev = {accel_x, accel_y, accel_z};
        end
    end

    task automatic release_and_time();
        int k = 0;
        @(negedge clk_in);
        rst = 1'b0;
        do begin
            @(negedge clk_in);
            k++;
        end while (!spi_request && k < 50);
        chk("first_request_latency", 64'(k), 64'd4);
    endtask

    task automatic wait_valid(input int target, input int budget);
        int k = 0;
        while (nvalid < target && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        if (nvalid < target) chk("valid_timeout", 64'(nvalid), 64'(target));
    endtask

    task automatic wait_req(input int target, input int budget);
        int k = 0;
        while (nreq < target && k < budget) begin
            @(negedge clk_in);
            k++;
        end
        if (nreq < target) chk("request_timeout", 64'(nreq), 64'(target));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_spi"}, {25'd0, spi_mosi_data, spi_nbits, spi_request}, 64'd0);
        chk({tag, "_accel"}, {16'd0, accel_x, accel_y, accel_z}, 64'd0);
        chk({tag, "_flags"}, {61'd0, data_valid, id_ok, id_err}, 64'd0);
    endtask

    int base;
    initial begin
        whoami = 8'h33;
        xv[0] = 16'h1234; yv[0] = 16'hFFFF; zv[0] = 16'h8000;
        for (int i = 1; i < 4; i++) begin
            xv[i] = 16'($urandom); yv[i] = 16'($urandom); zv[i] = 16'($urandom);
        end
        push_init();
        for (int i = 0; i < 3; i++) push_set(i, 1'b1);
        push_set(3, 1'b0);
        repeat (3) @(negedge clk_in);
        chk_outputs_zero("reset");

        release_and_time();
        wait_valid(3, 2000);
        chk("id_ok_after_match", {63'd0, id_ok}, 64'd1);
        chk("id_err_after_match", {63'd0, id_err}, 64'd0);

        // Abort during the Y transfer of the fourth set.
        wait_req(14, 300);
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        chk_outputs_zero("midreset");
        exp_req.delete();
        exp_out.delete();
        for (int i = 0; i < 4; i++) begin
            xv[i] = 16'($urandom); yv[i] = 16'($urandom); zv[i] = 16'($urandom);
        end
        push_init();
        push_set(0, 1'b1);
        base = nvalid;
        release_and_time();
        wait_valid(base + 1, 1000);
        repeat (5) @(negedge clk_in);
        chk("resequence_requests_left", 64'(exp_req.size()), 64'd0);
        chk("resequence_outputs_left", 64'(exp_out.size()), 64'd0);

        // Wrong WHO_AM_I: one request, then silence.
        rst = 1'b1;
        whoami = 8'h32;
        exp_req.delete();
        exp_out.delete();
        push_req(32'h0000_8F00, 6'd15);
        base = nreq;
        @(negedge clk_in);
        release_and_time();
        repeat (10000) @(negedge clk_in);
        chk("halt_request_count", 64'(nreq - base), 64'd1);
        chk("id_err_after_mismatch", {63'd0, id_err}, 64'd1);
        chk("id_ok_after_mismatch", {63'd0, id_ok}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
